ahb_bus_arbiter: RTL and testbench

Two-master AHB-lite arbiter that shares the single AHB address/data port feeding the AHB-APB bridge between two requesting masters. It grants the address phase to one master at a time with round-robin fairness and switches owners only on transfer boundaries, never mid-burst. It steers write data from the data-phase owner one cycle behind the address phase, and fans read data and `hready` back to both masters.

---
 rtl/ahb_bus_arbiter_pkg.sv | 23 ++
 rtl/ahb_bus_arbiter_if.sv | 53 +++++
 rtl/ahb_bus_arbiter_rr_pick.sv | 18 +
 rtl/ahb_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_bus_arbiter_pkg.sv
// ahb_pkg: definitions shared by the AHB-lite blocks (arbiter, masters, bridge).
//   - HTRANS_* : AHB transfer-type encodings
//   - arb_state_t : arbiter FSM state encoding
//   - is_active() : true for the transfer types that carry an address beat
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } arb_state_t;

    // NONSEQ and SEQ are the only real beats; BUSY behaves like IDLE here.
    function automatic logic is_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: every bus signal around the two-master arbiter.
//   master modport : the surroundings (two masters plus the bridge) that drive
//                    requests, address/data phases, hready and hrdata.
//   slave modport  : the arbiter, which returns grants, the muxed bus to the
//                    bridge and the hready/hrdata fanout to the masters.
interface ahb_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Master side
    logic              m0_hbusreq;
    logic              m1_hbusreq;
    logic [1:0]        m0_htrans;
    logic [1:0]        m1_htrans;
    logic              m0_hwrite;
    logic              m1_hwrite;
    logic [ADDR_W-1:0] m0_haddr;
    logic [ADDR_W-1:0] m1_haddr;
    logic [DATA_W-1:0] m0_hwdata;
    logic [DATA_W-1:0] m1_hwdata;
    logic              m0_hgrant;
    logic              m1_hgrant;
    logic [DATA_W-1:0] m0_hrdata;
    logic [DATA_W-1:0] m1_hrdata;
    logic              m0_hready;
    logic              m1_hready;

    // Bridge side
    logic              hready;
    logic [DATA_W-1:0] hrdata;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [ADDR_W-1:0] haddr;
    logic [DATA_W-1:0] hwdata;
    logic              hready_in;

    modport slave (
        input  m0_hbusreq, m1_hbusreq, m0_htrans, m1_htrans,
               m0_hwrite, m1_hwrite, m0_haddr, m1_haddr,
               m0_hwdata, m1_hwdata, hready, hrdata,
        output m0_hgrant, m1_hgrant, m0_hrdata, m1_hrdata,
               m0_hready, m1_hready, htrans, hwrite, haddr, hwdata, hready_in
    );

    modport master (
        output m0_hbusreq, m1_hbusreq, m0_htrans, m1_htrans,
               m0_hwrite, m1_hwrite, m0_haddr, m1_haddr,
               m0_hwdata, m1_hwdata, hready, hrdata,
        input  m0_hgrant, m1_hgrant, m0_hrdata, m1_hrdata,
               m0_hready, m1_hready, htrans, hwrite, haddr, hwdata, hready_in
    );

endinterface

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// ahb_rr_pick: combinational two-input round-robin picker.
//   req[1:0]   : request from master 1 / master 0
//   last_owner : master that was granted most recently
//   winner     : master to grant (0 or 1); meaningful only when any=1
//   any        : at least one request present
module ahb_rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner,
    output logic       any
);

    // A lone requester wins outright; on a tie the master that did not own
    // the bus last time goes first.
    assign any    = |req;
    assign winner = req[1] & (~req[0] | ~last_owner);

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: two-master AHB-lite arbiter in front of the AHB-APB bridge.
// Grants the address phase round-robin, hands over only on transfer
// boundaries, steers write data from the data-phase owner and fans
// hready/hrdata back to both masters.
//   hclk   : bus clock
//   hreset : synchronous active-high reset
//   bus    : ahb_bus_arbiter_if.slave (master requests/beats, bridge bus)
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic              hclk,
    input logic              hreset,
    ahb_bus_arbiter_if.slave bus
);

    arb_state_t        state;
    logic              last_owner;
    logic              grant0;
    logic              grant1;
    logic              ready_out;
    logic              dp_valid;
    logic              dp_owner;

    logic              pick_winner;
    logic              pick_any;
    logic              bnd0;
    logic              bnd1;
    logic [1:0]        trans_mux;
    logic              write_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    ahb_rr_pick u_pick (
        .req        ({bus.m1_hbusreq, bus.m0_hbusreq}),
        .last_owner (last_owner),
        .winner     (pick_winner),
        .any        (pick_any)
    );

    // A transfer boundary: the owner's current beat is not a real transfer
    // and the previous data phase is completing.
    assign bnd0 = bus.hready & ~is_active(bus.m0_htrans);
    assign bnd1 = bus.hready & ~is_active(bus.m1_htrans);

    // Address phase: straight mux from the owner, BUSY forwarded as IDLE.
    always_comb begin
        trans_mux = HTRANS_IDLE;
        write_mux = 1'b0;
        addr_mux  = '0;
        case (state)
            S_OWN0: begin
                trans_mux = is_active(bus.m0_htrans) ? bus.m0_htrans : HTRANS_IDLE;
                write_mux = bus.m0_hwrite;
                addr_mux  = bus.m0_haddr;
            end
            S_OWN1: begin
                trans_mux = is_active(bus.m1_htrans) ? bus.m1_htrans : HTRANS_IDLE;
                write_mux = bus.m1_hwrite;
                addr_mux  = bus.m1_haddr;
            end
            default: ;
        endcase
    end

    // Arbitration FSM with registered grants. Nothing moves while the bridge
    // stalls, so a new owner never starts under a pending data phase.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state      <= S_IDLE;
            last_owner <= 1'b1;
            grant0     <= 1'b0;
            grant1     <= 1'b0;
            ready_out  <= 1'b0;
        end else begin
            ready_out <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.hready && pick_any) begin
                        if (pick_winner) begin
                            state      <= S_OWN1;
                            grant1     <= 1'b1;
                            last_owner <= 1'b1;
                        end else begin
                            state      <= S_OWN0;
                            grant0     <= 1'b1;
                            last_owner <= 1'b0;
                        end
                    end
                end
                S_OWN0: begin
                    if (bnd0) begin
                        if (bus.m1_hbusreq) begin
                            state      <= S_OWN1;
                            grant0     <= 1'b0;
                            grant1     <= 1'b1;
                            last_owner <= 1'b1;
                        end else if (!bus.m0_hbusreq) begin
                            state  <= S_IDLE;
                            grant0 <= 1'b0;
                        end
                    end
                end
                S_OWN1: begin
                    if (bnd1) begin
                        if (bus.m0_hbusreq) begin
                            state      <= S_OWN0;
                            grant1     <= 1'b0;
                            grant0     <= 1'b1;
                            last_owner <= 1'b0;
                        end else if (!bus.m1_hbusreq) begin
                            state  <= S_IDLE;
                            grant1 <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    grant0 <= 1'b0;
                    grant1 <= 1'b0;
                end
            endcase
        end
    end

    // ---- address phase -> data phase boundary ----
    // The data phase follows whichever master owned the accepted address beat;
    // it freezes while hready is low.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            dp_valid <= 1'b0;
            dp_owner <= 1'b0;
        end else if (bus.hready) begin
            dp_valid <= is_active(trans_mux);
            if (is_active(trans_mux)) begin
                dp_owner <= (state == S_OWN1);
            end
        end
    end

    assign wdata_mux = !dp_valid ? '0 :
                       (dp_owner ? bus.m1_hwdata : bus.m0_hwdata);

    assign bus.m0_hgrant = grant0;
    assign bus.m1_hgrant = grant1;
    assign bus.htrans    = trans_mux;
    assign bus.hwrite    = write_mux;
    assign bus.haddr     = addr_mux;
    assign bus.hwdata    = wdata_mux;
    assign bus.hready_in = ready_out;
    assign bus.m0_hrdata = bus.hrdata;
    assign bus.m1_hrdata = bus.hrdata;
    assign bus.m0_hready = bus.hready;
    assign bus.m1_hready = bus.hready;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Testbench for ahb_bus_arbiter. Inputs are driven just after each rising
// edge, outputs sampled 1 ns later in the same cycle. Expected write data is
// queued when a write address beat is accepted and popped in its data phase.
module tb_ahb_bus_arbiter;
    import ahb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic        hclk = 1'b0;
    logic        hreset;
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] wq[$];
    logic [31:0] exp_w;

    ahb_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ahb_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    task automatic next();
        @(posedge hclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic quiet();
        bus.m0_hbusreq = 1'b0; bus.m1_hbusreq = 1'b0;
        bus.m0_htrans  = HTRANS_IDLE; bus.m1_htrans = HTRANS_IDLE;
        bus.m0_hwrite  = 1'b0; bus.m1_hwrite = 1'b0;
        bus.m0_haddr   = '0; bus.m1_haddr = '0;
        bus.m0_hwdata  = '0; bus.m1_hwdata = '0;
        bus.hready     = 1'b1;
        bus.hrdata     = '0;
    endtask

    task automatic test_reset();
        quiet();
        hreset = 1'b1;
        next(); next(); settle();
        n_cmp++; if ({bus.m0_hgrant, bus.m1_hgrant} !== 2'b00) begin n_fail++; $display("FAIL reset_grants: got %b required 00", {bus.m0_hgrant, bus.m1_hgrant}); end
        n_cmp++; if (bus.htrans !== HTRANS_IDLE || bus.hwrite !== 1'b0) begin n_fail++; $display("FAIL reset_trans: got htrans=%b hwrite=%b required 00/0", bus.htrans, bus.hwrite); end
        n_cmp++; if (bus.haddr !== 32'h0) begin n_fail++; $display("FAIL reset_haddr: got %h required 0", bus.haddr); end
        n_cmp++; if (bus.hwdata !== 32'h0) begin n_fail++; $display("FAIL reset_hwdata: got %h required 0", bus.hwdata); end
        n_cmp++; if (bus.hready_in !== 1'b0) begin n_fail++; $display("FAIL reset_hready_in: got %b required 0", bus.hready_in); end
        hreset = 1'b0;
        next(); settle();
        n_cmp++; if (bus.hready_in !== 1'b1) begin n_fail++; $display("FAIL post_reset_hready_in: got %b required 1", bus.hready_in); end
        next();
    endtask

    task automatic test_single_write();
        quiet();
        bus.m0_hbusreq = 1'b1; bus.m0_htrans = HTRANS_NONSEQ;
        bus.m0_hwrite = 1'b1; bus.m0_haddr = 32'h8000_0200;
        settle();
        n_cmp++; if (bus.m0_hgrant !== 1'b0) begin n_fail++; $display("FAIL sw_grant_early: got %b required 0", bus.m0_hgrant); end
        next(); settle();
        n_cmp++; if ({bus.m0_hgrant, bus.m1_hgrant} !== 2'b10) begin n_fail++; $display("FAIL sw_grant: got %b required 10", {bus.m0_hgrant, bus.m1_hgrant}); end
        n_cmp++; if (bus.haddr !== 32'h8000_0200 || bus.hwrite !== 1'b1 || bus.htrans !== HTRANS_NONSEQ) begin n_fail++; $display("FAIL sw_addr: got %h/%b/%b required 80000200/1/10", bus.haddr, bus.hwrite, bus.htrans); end
        wq.push_back(32'h0000_0024);
        next();
        bus.m0_htrans = HTRANS_IDLE; bus.m0_hbusreq = 1'b0; bus.m0_hwrite = 1'b0;
        bus.m0_hwdata = 32'h0000_0024;
        settle();
        exp_w = wq.pop_front();
        n_cmp++; if (bus.hwdata !== exp_w) begin n_fail++; $display("FAIL sw_hwdata: got %h required %h", bus.hwdata, exp_w); end
        next(); settle();
        n_cmp++; if (bus.m0_hgrant !== 1'b0 || bus.hwdata !== 32'h0) begin n_fail++; $display("FAIL sw_release: got grant=%b hwdata=%h required 0/0", bus.m0_hgrant, bus.hwdata); end
        next();
    endtask

    task automatic test_tie();
        quiet();
        hreset = 1'b1; settle(); next();
        hreset = 1'b0; settle(); next();
        bus.m0_hbusreq = 1'b1; bus.m0_htrans = HTRANS_NONSEQ; bus.m0_haddr = 32'h8000_0000;
        bus.m1_hbusreq = 1'b1; bus.m1_htrans = HTRANS_NONSEQ; bus.m1_haddr = 32'h8000_0100;
        settle(); next(); settle();
        n_cmp++; if ({bus.m0_hgrant, bus.m1_hgrant} !== 2'b10 || bus.haddr !== 32'h8000_0000) begin n_fail++; $display("FAIL tie_first: got grants=%b haddr=%h required 10/80000000", {bus.m0_hgrant, bus.m1_hgrant}, bus.haddr); end
        next();
        bus.m0_htrans = HTRANS_IDLE; bus.m0_hbusreq = 1'b0;
        settle();
        n_cmp++; if (bus.m0_hgrant !== 1'b1 || bus.htrans !== HTRANS_IDLE) begin n_fail++; $display("FAIL tie_dead_cycle: got grant0=%b htrans=%b required 1/00", bus.m0_hgrant, bus.htrans); end
        next(); settle();
        n_cmp++; if ({bus.m0_hgrant, bus.m1_hgrant} !== 2'b01 || bus.haddr !== 32'h8000_0100 || bus.htrans !== HTRANS_NONSEQ) begin n_fail++; $display("FAIL tie_second: got grants=%b haddr=%h htrans=%b required 01/80000100/10", {bus.m0_hgrant, bus.m1_hgrant}, bus.haddr, bus.htrans); end
        next();
        bus.m1_htrans = HTRANS_IDLE; bus.m1_hbusreq = 1'b0;
        settle(); next();
    endtask

    task automatic test_burst();
        quiet();
        bus.m0_hbusreq = 1'b1; bus.m0_htrans = HTRANS_NONSEQ; bus.m0_hwrite = 1'b1;
        bus.m0_haddr = 32'h8000_0020;
        settle(); next();
        for (int b = 0; b < 4; b++) begin
            bus.m0_htrans = (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            bus.m0_haddr  = 32'h8000_0020 + b;
            bus.m0_hwdata = (b > 0) ? (32'h1000_0000 + b - 1) : 32'h0;
            if (b >= 1) begin
                bus.m1_hbusreq = 1'b1; bus.m1_htrans = HTRANS_NONSEQ;
                bus.m1_hwrite = 1'b1; bus.m1_haddr = 32'h8000_0300;
            end
            settle();
            n_cmp++; if ({bus.m0_hgrant, bus.m1_hgrant} !== 2'b10 || bus.haddr !== 32'h8000_0020 + b) begin n_fail++; $display("FAIL burst_beat%0d: got grants=%b haddr=%h required 10/%h", b, {bus.m0_hgrant, bus.m1_hgrant}, bus.haddr, 32'h8000_0020 + b); end
            if (b > 0) begin
                exp_w = wq.pop_front();
                n_cmp++; if (bus.hwdata !== exp_w) begin n_fail++; $display("FAIL burst_hwdata%0d: got %h required %h", b, bus.hwdata, exp_w); end
            end
            wq.push_back(32'h1000_0000 + b);
            next();
        end
        bus.m0_htrans = HTRANS_IDLE; bus.m0_hbusreq = 1'b0; bus.m0_hwdata = 32'h1000_0003;
        settle();
        exp_w = wq.pop_front();
        n_cmp++; if ({bus.m0_hgrant, bus.m1_hgrant} !== 2'b10 || bus.htrans !== HTRANS_IDLE || bus.hwdata !== exp_w) begin n_fail++; $display("FAIL burst_end: got grants=%b htrans=%b hwdata=%h required 10/00/%h", {bus.m0_hgrant, bus.m1_hgrant}, bus.htrans, bus.hwdata, exp_w); end
        next(); settle();
        n_cmp++; if ({bus.m0_hgrant, bus.m1_hgrant} !== 2'b01 || bus.haddr !== 32'h8000_0300 || bus.hwdata !== 32'h0) begin n_fail++; $display("FAIL burst_handover: got grants=%b haddr=%h hwdata=%h required 01/80000300/0", {bus.m0_hgrant, bus.m1_hgrant}, bus.haddr, bus.hwdata); end
        wq.push_back(32'h0000_5A5A);
        next();
    endtask

    task automatic test_wait();
        bus.m1_htrans = HTRANS_NONSEQ; bus.m1_haddr = 32'h8000_0304; bus.m1_hwrite = 1'b1;
        bus.m1_hwdata = 32'h0000_5A5A; bus.m0_hwdata = 32'hDEAD_BEEF;
        bus.hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++; if ({bus.m0_hgrant, bus.m1_hgrant} !== 2'b01 || bus.haddr !== 32'h8000_0304) begin n_fail++; $display("FAIL wait_hold%0d: got grants=%b haddr=%h required 01/80000304", i, {bus.m0_hgrant, bus.m1_hgrant}, bus.haddr); end
            n_cmp++; if (bus.hwdata !== wq[0] || bus.m0_hready !== 1'b0 || bus.m1_hready !== 1'b0) begin n_fail++; $display("FAIL wait_data%0d: got hwdata=%h ready=%b%b required %h/00", i, bus.hwdata, bus.m0_hready, bus.m1_hready, wq[0]); end
            next();
        end
        bus.hready = 1'b1;
        settle();
        exp_w = wq.pop_front();
        n_cmp++; if (bus.hwdata !== exp_w || bus.m1_hgrant !== 1'b1) begin n_fail++; $display("FAIL wait_release: got hwdata=%h grant1=%b required %h/1", bus.hwdata, bus.m1_hgrant, exp_w); end
        wq.push_back(32'h0000_6B6B);
        next();
        bus.m1_htrans = HTRANS_IDLE; bus.m1_hbusreq = 1'b0; bus.m1_hwdata = 32'h0000_6B6B;
        settle();
        exp_w = wq.pop_front();
        n_cmp++; if (bus.hwdata !== exp_w) begin n_fail++; $display("FAIL wait_second_beat: got %h required %h", bus.hwdata, exp_w); end
        next();
    endtask

    task automatic test_reset_mid_burst();
        quiet();
        bus.m0_hbusreq = 1'b1; bus.m0_htrans = HTRANS_NONSEQ; bus.m0_hwrite = 1'b1;
        bus.m0_haddr = 32'h8000_0040;
        settle(); next();
        for (int b = 0; b < 3; b++) begin
            bus.m0_htrans = (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            bus.m0_haddr  = 32'h8000_0040 + b;
            bus.m0_hwdata = (b > 0) ? (32'h2000_0000 + b - 1) : 32'h0;
            if (b == 2) hreset = 1'b1;
            settle();
            if (b > 0) begin
                exp_w = wq.pop_front();
                n_cmp++; if (bus.hwdata !== exp_w) begin n_fail++; $display("FAIL rst_burst_hwdata%0d: got %h required %h", b, bus.hwdata, exp_w); end
            end
            wq.push_back(32'h2000_0000 + b);
            next();
        end
        bus.m0_hwdata = 32'h2000_0002;
        settle();
        wq.delete();
        n_cmp++; if ({bus.m0_hgrant, bus.m1_hgrant} !== 2'b00 || bus.htrans !== HTRANS_IDLE) begin n_fail++; $display("FAIL rst_mid_bus: got grants=%b htrans=%b required 00/00", {bus.m0_hgrant, bus.m1_hgrant}, bus.htrans); end
        n_cmp++; if (bus.hwdata !== 32'h0 || bus.hready_in !== 1'b0) begin n_fail++; $display("FAIL rst_mid_data: got hwdata=%h hready_in=%b required 0/0", bus.hwdata, bus.hready_in); end
        next();
        hreset = 1'b0;
        bus.m0_htrans = HTRANS_NONSEQ; bus.m0_hwrite = 1'b0; bus.m0_haddr = 32'h8000_0050;
        bus.m1_hbusreq = 1'b1; bus.m1_htrans = HTRANS_NONSEQ; bus.m1_haddr = 32'h8000_0150;
        settle(); next(); settle();
        n_cmp++; if ({bus.m0_hgrant, bus.m1_hgrant} !== 2'b10 || bus.hready_in !== 1'b1) begin n_fail++; $display("FAIL rst_rearb: got grants=%b hready_in=%b required 10/1", {bus.m0_hgrant, bus.m1_hgrant}, bus.hready_in); end
        next();
        quiet();
        settle(); next();
        settle(); next();
    endtask

    task automatic test_read();
        quiet();
        bus.m1_hbusreq = 1'b1; bus.m1_htrans = HTRANS_NONSEQ; bus.m1_hwrite = 1'b0;
        bus.m1_haddr = 32'h8000_0100;
        settle(); next(); settle();
        n_cmp++; if (bus.m1_hgrant !== 1'b1 || bus.haddr !== 32'h8000_0100 || bus.hwrite !== 1'b0) begin n_fail++; $display("FAIL read_addr: got grant1=%b haddr=%h hwrite=%b required 1/80000100/0", bus.m1_hgrant, bus.haddr, bus.hwrite); end
        next();
        bus.m1_htrans = HTRANS_IDLE; bus.m1_hbusreq = 1'b0; bus.hrdata = 32'hA5A5_0001;
        settle();
        n_cmp++; if (bus.m0_hrdata !== 32'hA5A5_0001 || bus.m1_hrdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL read_fanout: got m0=%h m1=%h required a5a50001", bus.m0_hrdata, bus.m1_hrdata); end
        next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_tie();
        test_burst();
        test_wait();
        test_reset_mid_burst();
        test_read();
        n_cmp++; if (wq.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries required 0", wq.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
